// File: rtl/ft64_regfile_wr_sched_pkg.sv
// rtl/ft64_regfile_wr_sched_pkg.sv - shared types and constants for the register-file write scheduler
// Purpose: state encoding, default address width and r0 detection used by the
//          scheduler and its interface.
// Contents: wrs_state_t, FT64_RBIT, FT64_AW, R0_MASK, is_r0().
package ft64_regfile_wr_sched_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } wrs_state_t;

    localparam int FT64_RBIT = 11;
    localparam int FT64_AW   = FT64_RBIT + 1;

    // Register 0 of every 32-entry bank is hardwired zero; writes to it are dropped.
    localparam logic [4:0] R0_MASK = 5'h1F;

    function automatic logic is_r0(input logic [4:0] field);
        return (field & R0_MASK) == 5'd0;
    endfunction

endpackage

// File: rtl/ft64_regfile_wr_sched_if.sv
// rtl/ft64_regfile_wr_sched_if.sv - writeback request bus and register-file write ports
// Purpose: bundles the NREQ writeback requesters and the two register-file
//          write ports driven by the scheduler.
// Ports (signals): req_v/req_wa/req_d in from requesters, req_rdy grants back,
//          wr0/wa0/i0/we0 and wr1/wa1/i1/we1 toward the register file, clr_busy.
// Modports: slave = scheduler side, master = requester / register-file side.
interface ft64_regfile_wr_sched_if #(
    parameter int WID  = 64,
    parameter int AW   = 12,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]     req_v;
    logic [NREQ*AW-1:0]  req_wa;
    logic [NREQ*WID-1:0] req_d;
    logic [NREQ-1:0]     req_rdy;
    logic                wr0;
    logic [AW-1:0]       wa0;
    logic [WID-1:0]      i0;
    logic                wr1;
    logic [AW-1:0]       wa1;
    logic [WID-1:0]      i1;
    logic [7:0]          we0;
    logic [7:0]          we1;
    logic                clr_busy;

    modport slave (
        input  req_v, req_wa, req_d,
        output req_rdy, wr0, wa0, i0, wr1, wa1, i1, we0, we1, clr_busy
    );

    modport master (
        output req_v, req_wa, req_d,
        input  req_rdy, wr0, wa0, i0, wr1, wa1, i1, we0, we1, clr_busy
    );
endinterface

// File: rtl/ft64_rr_pick2.sv
// rtl/ft64_rr_pick2.sv - combinational two-winner rotated-priority picker
// Purpose: scans req_v_i starting at ptr_i (wrapping mod NREQ) and reports the
//          first and second set bits found, for dual-issue arbitration.
// Ports: req_v_i request vector, ptr_i start index; a_v_o/a_idx_o first pick,
//        b_v_o/b_idx_o second pick.
module ft64_rr_pick2 #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_v_i,
    input  logic [PW-1:0]   ptr_i,
    output logic            a_v_o,
    output logic [PW-1:0]   a_idx_o,
    output logic            b_v_o,
    output logic [PW-1:0]   b_idx_o
);

    always_comb begin : pick
        int k;
        k       = 0;
        a_v_o   = 1'b0;
        a_idx_o = '0;
        b_v_o   = 1'b0;
        b_idx_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = (int'(ptr_i) + i) % NREQ;
            if (req_v_i[k]) begin
                if (!a_v_o) begin
                    a_v_o   = 1'b1;
                    a_idx_o = PW'(k);
                end else if (!b_v_o) begin
                    b_v_o   = 1'b1;
                    b_idx_o = PW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/ft64_regfile_wr_sched.sv
// rtl/ft64_regfile_wr_sched.sv - two-write-port register file writeback scheduler
// Purpose: after reset clears CLR_ENTRIES registers two per cycle, then grants up
//          to two writebacks per cycle round-robin onto register-file ports 0/1.
// Ports: clk, rst (sync, active-high); wb (slave modport) carrying the request
//        bus, grants, both write ports, byte enables and clr_busy.
module ft64_regfile_wr_sched
    import ft64_regfile_wr_sched_pkg::*;
#(
    parameter int WID         = 64,
    parameter int RBIT        = FT64_RBIT,
    parameter int NREQ        = 4,
    parameter int CLR_ENTRIES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    ft64_regfile_wr_sched_if.slave  wb
);

    localparam int AW = RBIT + 1;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW-1:0] CLR_LAST = AW'(CLR_ENTRIES - 2);

    wrs_state_t    state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic          wr0_q, wr0_d, wr1_q, wr1_d;
    logic [AW-1:0] wa0_q, wa0_d, wa1_q, wa1_d;
    logic [WID-1:0] i0_q, i0_d, i1_q, i1_d;
    logic [NREQ-1:0] rdy;

    logic          a_v, b_v;
    logic [PW-1:0] a_idx, b_idx;

    logic [AW-1:0]  wa_arr [NREQ];
    logic [WID-1:0] d_arr  [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign wa_arr[g] = wb.req_wa[g*AW +: AW];
        assign d_arr[g]  = wb.req_d[g*WID +: WID];
    end

    ft64_rr_pick2 #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req_v_i (wb.req_v),
        .ptr_i   (rr_ptr_q),
        .a_v_o   (a_v),
        .a_idx_o (a_idx),
        .b_v_o   (b_v),
        .b_idx_o (b_idx)
    );

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        wr0_d     = 1'b0;
        wa0_d     = wa0_q;
        i0_d      = i0_q;
        wr1_d     = 1'b0;
        wa1_d     = wa1_q;
        i1_d      = i1_q;
        rdy       = '0;
        case (state_q)
            ST_CLEAR: begin
                wr0_d     = 1'b1;
                wa0_d     = clr_cnt_q;
                i0_d      = '0;
                wr1_d     = 1'b1;
                wa1_d     = clr_cnt_q + AW'(1);
                i1_d      = '0;
                clr_cnt_d = clr_cnt_q + AW'(2);
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (a_v) begin
                    rdy[a_idx] = 1'b1;
                    wa0_d      = wa_arr[a_idx];
                    i0_d       = d_arr[a_idx];
                    // r0 writes are accepted and consume the slot, but never reach the file.
                    wr0_d      = !is_r0(wa_arr[a_idx][4:0]);
                    rr_ptr_d   = (a_idx == PW'(NREQ - 1)) ? '0 : a_idx + PW'(1);
                end
                if (b_v) begin
                    rdy[b_idx] = 1'b1;
                    wa1_d      = wa_arr[b_idx];
                    i1_d       = d_arr[b_idx];
                    wr1_d      = !is_r0(wa_arr[b_idx][4:0]);
                    rr_ptr_d   = (b_idx == PW'(NREQ - 1)) ? '0 : b_idx + PW'(1);
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            rr_ptr_q  <= '0;
            wr0_q     <= 1'b0;
            wa0_q     <= '0;
            i0_q      <= '0;
            wr1_q     <= 1'b0;
            wa1_q     <= '0;
            i1_q      <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            wr0_q     <= wr0_d;
            wa0_q     <= wa0_d;
            i0_q      <= i0_d;
            wr1_q     <= wr1_d;
            wa1_q     <= wa1_d;
            i1_q      <= i1_d;
        end
    end

    assign wb.req_rdy  = rdy;
    assign wb.wr0      = wr0_q;
    assign wb.wa0      = wa0_q;
    assign wb.i0       = i0_q;
    assign wb.wr1      = wr1_q;
    assign wb.wa1      = wa1_q;
    assign wb.i1       = i1_q;
    assign wb.we0      = 8'hFF;
    assign wb.we1      = 8'hFF;
    assign wb.clr_busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ft64_regfile_wr_sched.sv
// tb/tb_ft64_regfile_wr_sched.sv - directed self-checking bench for ft64_regfile_wr_sched
module tb_ft64_regfile_wr_sched;

    localparam int WID  = 64;
    localparam int AW   = 12;
    localparam int NREQ = 4;
    localparam int CLRN = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [WID-1:0] ref_mem [int];

    always #5 clk = ~clk;

    ft64_regfile_wr_sched_if #(.WID(WID), .AW(AW), .NREQ(NREQ)) bus ();

    ft64_regfile_wr_sched #(
        .WID(WID), .RBIT(AW-1), .NREQ(NREQ), .CLR_ENTRIES(CLRN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    task automatic set_req(input int k, input logic [AW-1:0] a, input logic [WID-1:0] d);
        bus.req_wa[k*AW +: AW]  = a;
        bus.req_d[k*WID +: WID] = d;
    endtask

    // Applies the visible port writes to the model register array in port order (0 then 1).
    task automatic apply_ref();
        if (bus.wr0) ref_mem[int'(bus.wa0)] = bus.i0;
        if (bus.wr1) ref_mem[int'(bus.wa1)] = bus.i1;
    endtask

    task automatic test_reset();
        bus.req_v = '0; bus.req_wa = '0; bus.req_d = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.wr0 !== 1'b0 || bus.wr1 !== 1'b0) begin errors++; $display("FAIL reset_wr got %b%b exp 00", bus.wr0, bus.wr1); end
        checks++; if (bus.wa0 !== 12'd0 || bus.i0 !== 64'd0) begin errors++; $display("FAIL reset_port0 got wa0=%h i0=%h exp 0", bus.wa0, bus.i0); end
        checks++; if (bus.req_rdy !== 4'b0000) begin errors++; $display("FAIL reset_rdy got %b exp 0000", bus.req_rdy); end
        checks++; if (bus.clr_busy !== 1'b1) begin errors++; $display("FAIL reset_clr_busy got %b exp 1", bus.clr_busy); end
    endtask

    task automatic test_clear();
        rst = 1'b0;
        bus.req_v = 4'b1111;
        for (int k = 1; k <= CLRN/2; k++) begin
            @(negedge clk);
            checks++; if (bus.wr0 !== 1'b1 || bus.wr1 !== 1'b1) begin errors++; $display("FAIL clear_wr[%0d] got %b%b exp 11", k, bus.wr0, bus.wr1); end
            checks++; if (bus.wa0 !== 12'(2*(k-1)) || bus.wa1 !== 12'(2*k-1)) begin errors++; $display("FAIL clear_wa[%0d] got %0d,%0d exp %0d,%0d", k, bus.wa0, bus.wa1, 2*(k-1), 2*k-1); end
            checks++; if (bus.i0 !== 64'd0 || bus.i1 !== 64'd0) begin errors++; $display("FAIL clear_data[%0d] got %h,%h exp 0", k, bus.i0, bus.i1); end
            checks++; if (bus.clr_busy !== (k < CLRN/2)) begin errors++; $display("FAIL clear_busy[%0d] got %b exp %b", k, bus.clr_busy, (k < CLRN/2)); end
            if (k < CLRN/2) begin
                checks++; if (bus.req_rdy !== 4'b0000) begin errors++; $display("FAIL clear_rdy[%0d] got %b exp 0000", k, bus.req_rdy); end
            end
            if (k == CLRN/2 - 1) bus.req_v = 4'b0000;
        end
        @(negedge clk);
        checks++; if (bus.wr0 !== 1'b0 || bus.wr1 !== 1'b0) begin errors++; $display("FAIL clear_done_wr got %b%b exp 00", bus.wr0, bus.wr1); end
    endtask

    task automatic test_round_robin();
        set_req(0, 12'd5, 64'h1005); set_req(1, 12'd6, 64'h1006);
        set_req(2, 12'd7, 64'h1007); set_req(3, 12'd8, 64'h1008);
        bus.req_v = 4'b1111;
        #1;
        checks++; if (bus.req_rdy !== 4'b0011) begin errors++; $display("FAIL rr1_rdy got %b exp 0011", bus.req_rdy); end
        @(negedge clk);
        checks++; if (bus.wa0 !== 12'd5 || bus.wa1 !== 12'd6 || bus.wr0 !== 1'b1 || bus.wr1 !== 1'b1) begin errors++; $display("FAIL rr1_out got wa0=%0d wa1=%0d wr=%b%b exp 5,6 11", bus.wa0, bus.wa1, bus.wr0, bus.wr1); end
        checks++; if (bus.i0 !== 64'h1005 || bus.i1 !== 64'h1006) begin errors++; $display("FAIL rr1_data got %h,%h exp 1005,1006", bus.i0, bus.i1); end
        bus.req_v = 4'b1100;
        #1;
        checks++; if (bus.req_rdy !== 4'b1100) begin errors++; $display("FAIL rr2_rdy got %b exp 1100", bus.req_rdy); end
        @(negedge clk);
        checks++; if (bus.wa0 !== 12'd7 || bus.wa1 !== 12'd8 || bus.wr0 !== 1'b1 || bus.wr1 !== 1'b1) begin errors++; $display("FAIL rr2_out got wa0=%0d wa1=%0d wr=%b%b exp 7,8 11", bus.wa0, bus.wa1, bus.wr0, bus.wr1); end
        // Pointer back at 0: requester 0 must win over 1 and 3.
        bus.req_v = 4'b1011;
        #1;
        checks++; if (bus.req_rdy !== 4'b0011) begin errors++; $display("FAIL rr_wrap_rdy got %b exp 0011", bus.req_rdy); end
        bus.req_v = 4'b0000;
        @(negedge clk);
        checks++; if (bus.wr0 !== 1'b0 || bus.wr1 !== 1'b0) begin errors++; $display("FAIL idle_wr got %b%b exp 00", bus.wr0, bus.wr1); end
    endtask

    task automatic test_wrap_grant();
        // Single grant of requester 2 moves the pointer to 3; port 1 keeps its old address/data.
        set_req(2, 12'd40, 64'h2040);
        bus.req_v = 4'b0100;
        #1;
        checks++; if (bus.req_rdy !== 4'b0100) begin errors++; $display("FAIL single_rdy got %b exp 0100", bus.req_rdy); end
        @(negedge clk);
        checks++; if (bus.wr0 !== 1'b1 || bus.wa0 !== 12'd40 || bus.wr1 !== 1'b0) begin errors++; $display("FAIL single_out got wr0=%b wa0=%0d wr1=%b exp 1,40,0", bus.wr0, bus.wa0, bus.wr1); end
        checks++; if (bus.wa1 !== 12'd8 || bus.i1 !== 64'h1008) begin errors++; $display("FAIL single_hold got wa1=%0d i1=%h exp 8,1008", bus.wa1, bus.i1); end
        set_req(3, 12'd50, 64'h3050); set_req(0, 12'd51, 64'h3051);
        bus.req_v = 4'b1001;
        #1;
        checks++; if (bus.req_rdy !== 4'b1001) begin errors++; $display("FAIL wrap_rdy got %b exp 1001", bus.req_rdy); end
        @(negedge clk);
        checks++; if (bus.wa0 !== 12'd50 || bus.wa1 !== 12'd51 || bus.i0 !== 64'h3050 || bus.i1 !== 64'h3051) begin errors++; $display("FAIL wrap_out got wa0=%0d wa1=%0d exp 50,51", bus.wa0, bus.wa1); end
        bus.req_v = 4'b0000;
    endtask

    task automatic test_same_addr();
        // Pointer is 1 here: A=1 on port 0, B=2 on port 1.
        set_req(1, 12'd12, 64'hAA); set_req(2, 12'd12, 64'hBB);
        bus.req_v = 4'b0110;
        #1;
        checks++; if (bus.req_rdy !== 4'b0110) begin errors++; $display("FAIL same_rdy got %b exp 0110", bus.req_rdy); end
        @(negedge clk);
        bus.req_v = 4'b0000;
        checks++; if (bus.wa0 !== 12'd12 || bus.wa1 !== 12'd12 || bus.i0 !== 64'hAA || bus.i1 !== 64'hBB) begin errors++; $display("FAIL same_out got wa=%0d,%0d i=%h,%h exp 12,12 aa,bb", bus.wa0, bus.wa1, bus.i0, bus.i1); end
        apply_ref();
        checks++; if (!ref_mem.exists(12) || ref_mem[12] !== 64'hBB) begin errors++; $display("FAIL same_final got %h exp bb", ref_mem.exists(12) ? ref_mem[12] : 64'hx); end
    endtask

    task automatic test_r0();
        // Pointer is 3: scan 3,0,1 -> A=0 (r0 of bank 1), B=1.
        set_req(0, 12'h020, 64'h77); set_req(1, 12'd9, 64'h99);
        bus.req_v = 4'b0011;
        #1;
        checks++; if (bus.req_rdy !== 4'b0011) begin errors++; $display("FAIL r0_rdy got %b exp 0011", bus.req_rdy); end
        @(negedge clk);
        bus.req_v = 4'b0000;
        checks++; if (bus.wr0 !== 1'b0 || bus.wa0 !== 12'h020) begin errors++; $display("FAIL r0_port0 got wr0=%b wa0=%h exp 0,020", bus.wr0, bus.wa0); end
        checks++; if (bus.wr1 !== 1'b1 || bus.wa1 !== 12'd9 || bus.i1 !== 64'h99) begin errors++; $display("FAIL r0_port1 got wr1=%b wa1=%0d exp 1,9", bus.wr1, bus.wa1); end
    endtask

    task automatic test_mid_reset();
        bus.req_v = 4'b1111;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.wr0 !== 1'b0 || bus.wr1 !== 1'b0) begin errors++; $display("FAIL mid_rst_wr got %b%b exp 00", bus.wr0, bus.wr1); end
        checks++; if (bus.req_rdy !== 4'b0000 || bus.clr_busy !== 1'b1) begin errors++; $display("FAIL mid_rst_ctl got rdy=%b busy=%b exp 0000,1", bus.req_rdy, bus.clr_busy); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.wr0 !== 1'b1 || bus.wa0 !== 12'd0 || bus.wa1 !== 12'd1) begin errors++; $display("FAIL mid_rst_restart got wr0=%b wa0=%0d wa1=%0d exp 1,0,1", bus.wr0, bus.wa0, bus.wa1); end
        checks++; if (bus.req_rdy !== 4'b0000) begin errors++; $display("FAIL mid_rst_rdy got %b exp 0000", bus.req_rdy); end
        bus.req_v = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_clear();
        test_round_robin();
        test_wrap_grant();
        test_same_addr();
        test_r0();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
